// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op encodings and
// the reference evaluation function used by the datapath.
package logic_unit_pkg;

   localparam int OP_W     = 3;
   // Widest operand lu_eval handles; narrower units zero-extend and truncate.
   localparam int LU_MAX_W = 64;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_NAND = 3'b011,
      OP_NOR  = 3'b100,
      OP_XNOR = 3'b101,
      OP_NOT  = 3'b110,
      OP_ANDN = 3'b111
   } lu_op_e;

   typedef logic [LU_MAX_W-1:0] lu_word_t;

   function automatic lu_word_t lu_eval(lu_op_e op, lu_word_t a, lu_word_t b);
      lu_word_t r;
      r = '0;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XNOR: r = ~(a ^ b);
         OP_NOT:  r = ~a;
         OP_ANDN: r = a & ~b;
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe. master = producer and
// consumer side (drives operands, accepts results); slave = the unit.
interface logic_unit_pipe_if #(parameter int WIDTH = 16);
   import logic_unit_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             zero;
   logic             parity;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, s, zero, parity
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, s, zero, parity
   );

endinterface

// File: rtl/logic_unit_pipe_stage.sv
// One valid/ready register slice. Loads whenever it is empty or its content
// is leaving this cycle; otherwise holds valid and data stable.
module lu_pipe_stage #(
   parameter int W = 18
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic load;

   assign load = ~out_valid | out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= in_valid;
         // Data only moves with a real beat; stale payload behind valid=0 is harmless.
         if (in_valid) out_data <= in_data;
      end
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: evaluates op/a/b plus zero/parity flags ahead
// of the first register, then moves the beat through STAGES valid/ready slices.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   logic_unit_pipe_if.slave bus
);

   localparam int PW = WIDTH + 2;

   logic [WIDTH-1:0]           res;
   logic                       res_zero;
   logic                       res_par;
   logic [STAGES:0]            vld_pipe;
   logic [STAGES:0]            rdy_pipe;
   logic [STAGES:0][PW-1:0]    dat_pipe;

   assign res      = WIDTH'(lu_eval(lu_op_e'(bus.op), lu_word_t'(bus.a), lu_word_t'(bus.b)));
   assign res_zero = ~|res;
   assign res_par  = ^res;

   assign vld_pipe[0] = bus.in_valid;
   assign dat_pipe[0] = {res_par, res_zero, res};

   // Stage k may load when any register from k to the output has a hole or the
   // consumer is taking a beat: closed form of ready_k = ~valid_k | ready_(k+1),
   // built from register state only so there is no combinational ready chain.
   assign rdy_pipe[STAGES] = bus.out_ready;
   for (genvar k = 0; k < STAGES; k++) begin : g_rdy
      assign rdy_pipe[k] = bus.out_ready | ~(&vld_pipe[STAGES:k+1]);
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      lu_pipe_stage #(.W(PW)) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (vld_pipe[k]),
         .in_data   (dat_pipe[k]),
         .out_valid (vld_pipe[k+1]),
         .out_ready (rdy_pipe[k+1]),
         .out_data  (dat_pipe[k+1])
      );
   end

   assign bus.in_ready                  = rdy_pipe[0];
   assign bus.out_valid                 = vld_pipe[STAGES];
   assign {bus.parity, bus.zero, bus.s} = dat_pipe[STAGES];

endmodule
